// File: rtl/uart_rx_fifo.sv
// Receive-side first-word-fall-through byte FIFO with sticky overflow and BREAK status.
// Latency: a byte strobed at edge N appears on m_valid/m_data after edge N (1 cycle).
// Backpressure: m_ready stalls the head; when full, a push is dropped and overflow is set, unless a pop happens in the same cycle.
//
// Ports:
//   clk, resetn            clock and synchronous active-low reset
//   rx_valid/rx_data/rx_break  single-cycle receive strobe with its byte and BREAK flag
//   clear                  synchronous flush of the FIFO and the sticky flags
//   m_valid/m_data/m_ready valid/ready output stream of buffered bytes
//   level                  number of stored bytes, 0..DEPTH
//   overflow, break_seen   sticky status flags
module uart_rx_fifo #(
    parameter int DEPTH      = 16,
    parameter int WIDTH      = 8,
    parameter int DROP_BREAK = 1
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       rx_valid,
    input  logic [WIDTH-1:0]           rx_data,
    input  logic                       rx_break,
    input  logic                       clear,
    output logic                       m_valid,
    output logic [WIDTH-1:0]           m_data,
    input  logic                       m_ready,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       overflow,
    output logic                       break_seen
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic [AW:0]      level_q;
    logic             overflow_q;
    logic             break_q;

    logic             full;
    logic             pop;
    logic             push_req;
    logic             push;

    assign full     = (level_q == (AW+1)'(DEPTH));
    assign pop      = m_valid && m_ready;
    // BREAK characters bypass storage entirely when DROP_BREAK is set.
    assign push_req = rx_valid && !(rx_break && (DROP_BREAK != 0));
    // A full FIFO still accepts a byte if the head leaves in the same cycle.
    assign push     = push_req && (!full || pop);

    // Outputs depend only on registers, so the stream has no input-to-output path.
    assign m_valid    = (level_q != '0);
    assign m_data     = m_valid ? mem[rd_ptr] : '0;
    assign level      = level_q;
    assign overflow   = overflow_q;
    assign break_seen = break_q;

    // Storage is not reset; only the pointers and level decide what is valid.
    always_ff @(posedge clk) begin
        if (resetn && !clear && push) begin
            mem[wr_ptr] <= rx_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn || clear) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
            break_q    <= 1'b0;
        end else begin
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   level_q <= level_q + (AW+1)'(1);
                2'b01:   level_q <= level_q - (AW+1)'(1);
                default: level_q <= level_q;
            endcase
            if (push_req && !push) begin
                overflow_q <= 1'b1;
            end
            if (rx_valid && rx_break) begin
                break_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: two instances (BREAK dropped / BREAK stored)
// share one stimulus stream; a queue-based model per instance is compared every cycle,
// and directed literal expectations pin the model to hand-computed values.
module tb_uart_rx_fifo;

    localparam int DEPTH = 16;
    localparam int WIDTH = 8;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             resetn = 1'b0;
    logic             rx_valid = 1'b0;
    logic [WIDTH-1:0] rx_data = '0;
    logic             rx_break = 1'b0;
    logic             clear = 1'b0;
    logic             m_ready = 1'b0;

    logic             m_valid1, m_valid0;
    logic [WIDTH-1:0] m_data1, m_data0;
    logic [LW-1:0]    level1, level0;
    logic             overflow1, overflow0;
    logic             break1, break0;

    int errors = 0;
    int checks = 0;
    bit checking = 1'b0;

    always #5 clk = ~clk;

    uart_rx_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH), .DROP_BREAK(1)) dut (
        .clk(clk), .resetn(resetn), .rx_valid(rx_valid), .rx_data(rx_data),
        .rx_break(rx_break), .clear(clear), .m_valid(m_valid1), .m_data(m_data1),
        .m_ready(m_ready), .level(level1), .overflow(overflow1), .break_seen(break1)
    );

    uart_rx_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH), .DROP_BREAK(0)) dut0 (
        .clk(clk), .resetn(resetn), .rx_valid(rx_valid), .rx_data(rx_data),
        .rx_break(rx_break), .clear(clear), .m_valid(m_valid0), .m_data(m_data0),
        .m_ready(m_ready), .level(level0), .overflow(overflow0), .break_seen(break0)
    );

    // ---------------- model: a queue of bytes plus two flags per instance -------------
    logic [WIDTH-1:0] q1 [$];
    logic [WIDTH-1:0] q0 [$];
    bit ovf1_m = 0, brk1_m = 0, ovf0_m = 0, brk0_m = 0;

    always @(posedge clk) begin
        bit was_full, popped;
        if (!resetn || clear) begin
            q1.delete(); q0.delete();
            ovf1_m = 0; brk1_m = 0; ovf0_m = 0; brk0_m = 0;
        end else begin
            // instance that drops BREAK characters
            was_full = (q1.size() == DEPTH);
            popped   = (q1.size() != 0) && m_ready;
            if (popped) void'(q1.pop_front());
            if (rx_valid && !rx_break) begin
                if (!was_full || popped) q1.push_back(rx_data);
                else ovf1_m = 1;
            end
            if (rx_valid && rx_break) brk1_m = 1;
            // instance that stores BREAK characters
            was_full = (q0.size() == DEPTH);
            popped   = (q0.size() != 0) && m_ready;
            if (popped) void'(q0.pop_front());
            if (rx_valid) begin
                if (!was_full || popped) q0.push_back(rx_data);
                else ovf0_m = 1;
            end
            if (rx_valid && rx_break) brk0_m = 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Single compare process: every cycle after the first reset edge.
    always @(negedge clk) begin
        if (checking) begin
            chk("d1.level",    32'(level1),    32'(q1.size()));
            chk("d1.m_valid",  32'(m_valid1),  32'(q1.size() != 0));
            chk("d1.m_data",   32'(m_data1),   (q1.size() != 0) ? 32'(q1[0]) : 32'd0);
            chk("d1.overflow", 32'(overflow1), 32'(ovf1_m));
            chk("d1.break",    32'(break1),    32'(brk1_m));
            chk("d0.level",    32'(level0),    32'(q0.size()));
            chk("d0.m_valid",  32'(m_valid0),  32'(q0.size() != 0));
            chk("d0.m_data",   32'(m_data0),   (q0.size() != 0) ? 32'(q0[0]) : 32'd0);
            chk("d0.overflow", 32'(overflow0), 32'(ovf0_m));
            chk("d0.break",    32'(break0),    32'(brk0_m));
        end
    end

    // Advance one clock; inputs change on the falling edge, away from the active edge.
    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic push_byte(input logic [7:0] b);
        rx_valid = 1'b1; rx_data = b; rx_break = 1'b0;
        cyc();
        rx_valid = 1'b0;
    endtask

    initial begin
        // Reset state
        cyc(); cyc();
        checking = 1'b1;
        chk("rst.level", 32'(level1), 0);
        chk("rst.m_valid", 32'(m_valid1), 0);
        chk("rst.m_data", 32'(m_data1), 0);
        chk("rst.overflow", 32'(overflow1), 0);
        chk("rst.break", 32'(break1), 0);
        resetn = 1'b1;

        // 1: three bytes, then drain
        push_byte(8'h41); push_byte(8'h42); push_byte(8'h43);
        chk("t1.level", 32'(level1), 3);
        chk("t1.head", 32'(m_data1), 32'h41);
        m_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("t1.order", 32'(m_data1), 32'h41 + i);
            cyc();
        end
        m_ready = 1'b0;
        chk("t1.empty_valid", 32'(m_valid1), 0);
        chk("t1.empty_data", 32'(m_data1), 0);
        chk("t1.empty_level", 32'(level1), 0);

        // 2: fill to DEPTH, overflow, drain in order
        for (int i = 0; i < DEPTH; i++) push_byte(8'(i));
        push_byte(8'hAA);
        chk("t2.level", 32'(level1), 16);
        chk("t2.overflow", 32'(overflow1), 1);
        chk("t2.head", 32'(m_data1), 0);
        m_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            chk("t2.order", 32'(m_data1), i);
            cyc();
        end
        m_ready = 1'b0;
        chk("t2.drained", 32'(m_valid1), 0);

        // 3: push into a full FIFO while popping
        clear = 1'b1; cyc(); clear = 1'b0;
        for (int i = 0; i < DEPTH; i++) push_byte(8'h10 + 8'(i));
        m_ready = 1'b1;
        push_byte(8'h55);
        m_ready = 1'b0;
        chk("t3.overflow", 32'(overflow1), 0);
        chk("t3.level", 32'(level1), 16);
        m_ready = 1'b1;
        for (int i = 0; i < DEPTH - 1; i++) begin
            chk("t3.order", 32'(m_data1), 32'h11 + i);
            cyc();
        end
        chk("t3.last", 32'(m_data1), 32'h55);
        cyc();
        m_ready = 1'b0;
        chk("t3.level_end", 32'(level1), 0);

        // 4: BREAK dropped vs stored
        rx_valid = 1'b1; rx_break = 1'b1; rx_data = 8'h00;
        cyc();
        rx_valid = 1'b0; rx_break = 1'b0;
        chk("t4.drop_level", 32'(level1), 0);
        chk("t4.drop_break", 32'(break1), 1);
        chk("t4.keep_level", 32'(level0), 1);
        chk("t4.keep_valid", 32'(m_valid0), 1);
        chk("t4.keep_head", 32'(m_data0), 0);
        chk("t4.keep_break", 32'(break0), 1);

        // 5: continuous stream through the FIFO, wrapping the pointers
        clear = 1'b1; cyc(); clear = 1'b0;
        m_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            push_byte(8'h80 + 8'(i));
            chk("t5.data", 32'(m_data1), 32'h80 + i);
            chk("t5.level", 32'(level1), 1);
        end
        cyc();
        cyc(); // m_ready while empty must do nothing
        m_ready = 1'b0;
        chk("t5.level_end", 32'(level1), 0);
        chk("t5.overflow", 32'(overflow1), 0);

        // 6: clear beats a same-cycle push, overflow and BREAK
        for (int i = 0; i < DEPTH; i++) push_byte(8'h20 + 8'(i));
        push_byte(8'hEE);
        m_ready = 1'b1;
        for (int i = 0; i < 11; i++) cyc();
        m_ready = 1'b0;
        chk("t6.level5", 32'(level1), 5);
        chk("t6.ovf_set", 32'(overflow1), 1);
        clear = 1'b1; rx_valid = 1'b1; rx_data = 8'h77; rx_break = 1'b1;
        cyc();
        clear = 1'b0; rx_valid = 1'b0; rx_break = 1'b0;
        chk("t6.level", 32'(level1), 0);
        chk("t6.m_valid", 32'(m_valid1), 0);
        chk("t6.overflow", 32'(overflow1), 0);
        chk("t6.break", 32'(break1), 0);
        chk("t6.break0", 32'(break0), 0);
        push_byte(8'h12);
        chk("t6.readback", 32'(m_data1), 32'h12);

        // 7: reset mid-stream (reset wins over clear), first byte after reset is kept
        push_byte(8'h61); push_byte(8'h62);
        resetn = 1'b0; clear = 1'b1; rx_valid = 1'b1; rx_data = 8'h99;
        cyc();
        resetn = 1'b1; clear = 1'b0;
        push_byte(8'h34);
        chk("t7.level", 32'(level1), 1);
        chk("t7.head", 32'(m_data1), 32'h34);
        cyc();

        checking = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Receive-side byte buffer that sits directly downstream of the UART receiver. It captures each single-cycle received-byte strobe (with its data and break indication) into a first-word-fall-through FIFO. It presents the buffered bytes to the consuming logic on a valid/ready stream. It also keeps sticky status for overflow and BREAK conditions, so that bytes arriving faster than the consumer drains them are never silently lost.

Parameters:
DEPTH, 16, number of byte entries; must be a power of 2 and >= 2.
WIDTH, 8, data width; matches the receiver payload width.
DROP_BREAK, 1, 1 = BREAK characters are not stored and only set break_seen; 0 = BREAK characters are stored as 0x00 and also set break_seen.

Ports:
clk  in  1  system clock.
resetn  in  1  synchronous active-low reset.
rx_valid  in  1  single-cycle strobe: a byte has been received.
rx_data  in  WIDTH  received byte; qualified by rx_valid.
rx_break  in  1  the received byte was a BREAK; qualified by rx_valid.
clear  in  1  synchronous flush of the FIFO and all sticky flags.
m_valid  out  1  FIFO head holds data.
m_data  out  WIDTH  FIFO head byte.
m_ready  in  1  consumer accepts the head byte.
level  out  $clog2(DEPTH)+1  current number of stored bytes, 0..DEPTH.
overflow  out  1  sticky: at least one byte was dropped because the FIFO was full.
break_seen  out  1  sticky: at least one BREAK has been received.

Behaviour:
- Reset (resetn=0 at a clk edge): level=0, m_valid=0, m_data=0, overflow=0, break_seen=0; read and write pointers=0. Memory contents are not reset.
- Storage: DEPTH x WIDTH array with log2(DEPTH)-bit read/write pointers that wrap naturally modulo DEPTH, plus a separate level counter. Full is level==DEPTH; empty is level==0.
- Outputs:
  - m_valid = (level != 0).
  - m_data = mem[rd_ptr] when m_valid=1, otherwise 0 (combinational from registered state).
  - level, m_valid and m_data are glitch-free functions of registers only; there is no combinational path from any input to any output.
- Pop: occurs when m_valid && m_ready; rd_ptr increments at the clk edge. m_ready while empty has no effect.
- Push request: rx_valid && !(rx_break && DROP_BREAK).
  - The stored value is rx_data. When DROP_BREAK=0 and rx_break=1, rx_data is 0x00 from the receiver and is stored as-is.
- Push accept: a push request is accepted if level<DEPTH, or if level==DEPTH and a pop occurs in the same cycle.
  - An accepted push writes mem[wr_ptr] and increments wr_ptr.
- Level update: +1 on push only, -1 on pop only, unchanged on push+pop or on neither.
- Overflow: a push request that is not accepted drops the byte and sets overflow=1 at the same edge. Pointers and level are unchanged.
- Break: rx_valid && rx_break sets break_seen=1 regardless of DROP_BREAK or FIFO fullness.
- Latency: a byte strobed at edge N (rx_valid sampled high) is visible as m_valid=1/m_data at cycle N+1 when the FIFO was empty. The minimum fall-through is 1 cycle.
- Throughput: one push and one pop per cycle sustained.
- clear=1 (with resetn=1):
  - Next state equals reset state except memory contents.
  - Takes priority over a same-cycle push, pop, overflow set and break_seen set; the strobed byte is discarded and the flags end at 0.
- resetn has priority over clear.
- Reset mid-stream: all buffered data is lost; the first rx_valid after reset deassertion is stored normally.
- Sticky flags clear only via resetn or clear.

Test Plan:
1. Reset, then push 0x41, 0x42, 0x43 on three consecutive cycles with m_ready=0 -> level=3, m_data=0x41. Assert m_ready for 3 cycles -> m_data sequence 0x41,0x42,0x43, then m_valid=0, m_data=0, level=0.
2. DEPTH=16: push 0x00..0x0F with m_ready=0, then push 0xAA -> level=16, overflow=1, head still 0x00. Drain all -> order 0x00..0x0F; 0xAA never appears.
3. Full FIFO: push 0x55 with m_ready=1 in the same cycle -> no overflow, level stays 16; after draining, 0x55 is the last byte out.
4. DROP_BREAK=1: rx_valid with rx_break=1, rx_data=0x00 -> break_seen=1, level unchanged. DROP_BREAK=0: same stimulus -> level+1 and head=0x00.
5. Wrap-around: 40 bytes of an incrementing pattern pushed and popped continuously with m_ready=1 -> output identical in order, level never exceeds 1, overflow=0.
6. With level=5 and overflow=1, assert clear together with rx_valid (0x77) and rx_break=1 -> next cycle level=0, m_valid=0, overflow=0, break_seen=0. A subsequent push of 0x12 is read back as 0x12.
